sram_write_scheduler: RTL and testbench
=======================================

SRAM_WRITE_SCHEDULER -- requirements
Module: sram_write_scheduler

Interface
REQ-001 The block SHALL have parameter WE_CYCLES, default 2, setting the SRAM_WE_N low width in clock cycles (legal 1..15).
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port REQ_A, input, 1 bit, requester A has a valid word on DATA_A.
REQ-005 The block SHALL have port DATA_A, input, 16 bits, requester A write word.
REQ-006 The block SHALL have port ACK_A, output, 1 bit, one-cycle pulse: A's word is written.
REQ-007 The block SHALL have ports REQ_B, DATA_B and ACK_B, identical to REQ-004 to REQ-006 for requester B.
REQ-008 The block SHALL have port SRAM_ADDR, output, 18 bits, word address within the selected chip.
REQ-009 The block SHALL have port SRAM_DATA, output, 16 bits, latched write data.
REQ-010 The block SHALL have port SRAM_CE_N, output, 2 bits, active-low chip enables; bit 0 is chip 0 and bit 1 is chip 1.
REQ-011 The block SHALL have port SRAM_WE_N, output, 1 bit, active-low write strobe.
REQ-012 The block SHALL have port BUSY, output, 1 bit, high whenever the state is not IDLE.
REQ-013 The block SHALL have port FULL, output, 1 bit, high when both chips are completely written.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, WRITE and HOLD, and every output SHALL be registered.
REQ-015 In IDLE, with FULL low and at least one REQ high, the block SHALL grant one requester, latch its DATA into SRAM_DATA and go to SETUP.
REQ-016 Simultaneous REQ_A and REQ_B SHALL be granted round-robin: the requester not granted last wins, and A wins the first tie after reset.
REQ-017 SETUP SHALL last 1 cycle, with the current chip's CE_N low, WE_N high and address/data stable.
REQ-018 WRITE SHALL last exactly WE_CYCLES cycles with WE_N low, then go to HOLD.
REQ-019 HOLD SHALL last 1 cycle with WE_N high, CE_N still low, and ACK high for the granted requester only, then return to IDLE.
REQ-020 At the end of HOLD, CE_N SHALL return to 2'b11 and the address SHALL advance by 1.
REQ-021 When a write completes at address 0x3FFFF on chip 0, the address SHALL become 0 and the chip select SHALL move to chip 1.
REQ-022 When a write completes at address 0x3FFFF on chip 1, FULL SHALL assert.
REQ-023 While FULL is high, requests SHALL be ignored: no grant and no ACK.
REQ-024 Each word SHALL take 3+WE_CYCLES cycles from the IDLE sampling edge to the end of HOLD (5 cycles with the default).
REQ-025 A requester SHALL hold REQ and DATA until ACK; it may update them at the edge that ends the ACK cycle.
REQ-026 A REQ drop after grant SHALL NOT abort the write, because the data is already latched.
REQ-027 A requester that keeps REQ high after ACK SHALL be treated as presenting a new word.

Reset
REQ-028 When RESET is high at a clock edge, the block SHALL enter IDLE with SRAM_ADDR=0, chip 0 selected, SRAM_DATA=0, SRAM_CE_N=2'b11, SRAM_WE_N=1, ACK_A=ACK_B=0, BUSY=0, FULL=0, and B recorded as last granted.
REQ-029 A reset during SETUP, WRITE or HOLD SHALL abort the write and drive WE_N/CE_N inactive on that edge, with no ACK issued.

Configuration
REQ-030 With macro SRAM_WRAP_EN defined, completing 0x3FFFF on chip 1 SHALL wrap to chip 0, address 0; FULL SHALL stay 0 and requests SHALL continue to be served.
REQ-031 Without SRAM_WRAP_EN, the behaviour SHALL be as REQ-022 and REQ-023.

Verification
REQ-032 The bench SHALL check a single write: REQ_A=1 with DATA_A=0xBEEF -> CE_N=2'b10, WE_N low for 2 cycles, SRAM_DATA=0xBEEF at ADDR 0, ACK_A pulse on cycle 5, then ADDR=1.
REQ-033 The bench SHALL check arbitration: REQ_A and REQ_B held high for 4 words -> grants A, B, A, B; ADDR 0..3; ACKs alternate.
REQ-034 The bench SHALL check the chip boundary: preload address to 0x3FFFF on chip 0, write once -> next write goes to ADDR 0 with CE_N=2'b01.
REQ-035 The bench SHALL check the full condition: last write at chip 1 address 0x3FFFF -> FULL=1, and a further REQ_B gets no ACK and WE_N stays high (with SRAM_WRAP_EN: FULL=0 and the next write goes to chip 0 ADDR 0).
REQ-036 The bench SHALL check reset mid-write: RESET=1 during WRITE -> next edge gives WE_N=1, CE_N=2'b11, ADDR=0, no ACK.
REQ-037 The bench SHALL check the parameter: WE_CYCLES=4 -> WE_N low for exactly 4 cycles and 7 cycles per word.

Source files
------------

// File: rtl/sram_write_scheduler.sv
// Two-requester write scheduler for a pair of 256K x 16 asynchronous SRAM chips.
// Optional macro SRAM_WRAP_EN: wrap from chip 1 back to chip 0 instead of raising FULL.
module sram_write_scheduler #(
   parameter int WE_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ_A,
   input  logic [15:0] DATA_A,
   output logic        ACK_A,
   input  logic        REQ_B,
   input  logic [15:0] DATA_B,
   output logic        ACK_B,
   output logic [17:0] SRAM_ADDR,
   output logic [15:0] SRAM_DATA,
   output logic [1:0]  SRAM_CE_N,
   output logic        SRAM_WE_N,
   output logic        BUSY,
   output logic        FULL
);

   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_SETUP = 2'd1;
   localparam logic [1:0]  S_WRITE = 2'd2;
   localparam logic [1:0]  S_HOLD  = 2'd3;
   localparam logic [3:0]  WE_LAST = 4'(WE_CYCLES - 1);
   localparam logic [17:0] ADDR_MAX = 18'h3FFFF;

   logic [1:0]  r_state, w_state;
   logic [3:0]  r_cnt, w_cnt;
   logic [17:0] r_addr, w_addr;
   logic        r_chip, w_chip;
   logic [15:0] r_data, w_data;
   logic [1:0]  r_ce_n, w_ce_n;
   logic        r_we_n, w_we_n;
   logic        r_ack_a, w_ack_a;
   logic        r_ack_b, w_ack_b;
   logic        r_busy, w_busy;
   logic        r_full, w_full;
   logic        r_last_b, w_last_b;
   logic        r_gnt_b, w_gnt_b;

   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_addr   = r_addr;
      w_chip   = r_chip;
      w_data   = r_data;
      w_ce_n   = r_ce_n;
      w_we_n   = r_we_n;
      w_ack_a  = 1'b0;
      w_ack_b  = 1'b0;
      w_full   = r_full;
      w_last_b = r_last_b;
      w_gnt_b  = r_gnt_b;
      case (r_state)
         S_IDLE: begin
            if (!r_full && (REQ_A || REQ_B)) begin
               // on a tie the requester not served last wins
               w_gnt_b  = REQ_B && (!REQ_A || !r_last_b);
               w_last_b = w_gnt_b;
               w_data   = w_gnt_b ? DATA_B : DATA_A;
               w_ce_n   = r_chip ? 2'b01 : 2'b10;
               w_state  = S_SETUP;
            end
         end
         S_SETUP: begin
            w_state = S_WRITE;
            w_we_n  = 1'b0;
            w_cnt   = WE_LAST;
         end
         S_WRITE: begin
            if (r_cnt == 4'd0) begin
               w_state = S_HOLD;
               w_we_n  = 1'b1;
               w_ack_a = !r_gnt_b;
               w_ack_b = r_gnt_b;
            end else begin
               w_cnt = r_cnt - 4'd1;
            end
         end
         S_HOLD: begin
            w_state = S_IDLE;
            w_ce_n  = 2'b11;
            if (r_addr == ADDR_MAX) begin
               w_addr = 18'd0;
               if (!r_chip) begin
                  w_chip = 1'b1;
               end else begin
`ifdef SRAM_WRAP_EN
                  w_chip = 1'b0;
`else
                  w_full = 1'b1;
`endif
               end
            end else begin
               w_addr = r_addr + 18'd1;
            end
         end
         default: w_state = S_IDLE;
      endcase
      w_busy = (w_state != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_addr   <= 18'd0;
         r_chip   <= 1'b0;
         r_data   <= 16'd0;
         r_ce_n   <= 2'b11;
         r_we_n   <= 1'b1;
         r_ack_a  <= 1'b0;
         r_ack_b  <= 1'b0;
         r_busy   <= 1'b0;
         r_full   <= 1'b0;
         r_last_b <= 1'b1;
         r_gnt_b  <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_addr   <= w_addr;
         r_chip   <= w_chip;
         r_data   <= w_data;
         r_ce_n   <= w_ce_n;
         r_we_n   <= w_we_n;
         r_ack_a  <= w_ack_a;
         r_ack_b  <= w_ack_b;
         r_busy   <= w_busy;
         r_full   <= w_full;
         r_last_b <= w_last_b;
         r_gnt_b  <= w_gnt_b;
      end
   end

   assign ACK_A     = r_ack_a;
   assign ACK_B     = r_ack_b;
   assign SRAM_ADDR = r_addr;
   assign SRAM_DATA = r_data;
   assign SRAM_CE_N = r_ce_n;
   assign SRAM_WE_N = r_we_n;
   assign BUSY      = r_busy;
   assign FULL      = r_full;

endmodule

// File: tb/tb_sram_write_scheduler.sv
// Bench for sram_write_scheduler: directed scenarios plus random traffic
// against a word-level model, on WE_CYCLES=2 and WE_CYCLES=4 instances.
module tb_sram_write_scheduler;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        REQ_A, REQ_B;
   logic [15:0] DATA_A, DATA_B;

   logic        ack_a2, ack_b2, we2, busy2, full2;
   logic [17:0] addr2;
   logic [15:0] data2;
   logic [1:0]  ce2;
   logic        ack_a4, ack_b4, we4, busy4, full4;
   logic [17:0] addr4;
   logic [15:0] data4;
   logic [1:0]  ce4;

   logic        unit;
   logic        m_ack_a, m_ack_b, m_we_n, m_busy, m_full_o;
   logic [17:0] m_addr_o;
   logic [15:0] m_data_o;
   logic [1:0]  m_ce_n;

   int n_checks = 0;
   int n_errors = 0;

   logic [17:0] m_addr;
   logic        m_chip, m_full, m_last_b;

   sram_write_scheduler #(.WE_CYCLES(2)) u_dut2 (
      .CLK(CLK), .RESET(RESET),
      .REQ_A(REQ_A), .DATA_A(DATA_A), .ACK_A(ack_a2),
      .REQ_B(REQ_B), .DATA_B(DATA_B), .ACK_B(ack_b2),
      .SRAM_ADDR(addr2), .SRAM_DATA(data2), .SRAM_CE_N(ce2),
      .SRAM_WE_N(we2), .BUSY(busy2), .FULL(full2)
   );

   sram_write_scheduler #(.WE_CYCLES(4)) u_dut4 (
      .CLK(CLK), .RESET(RESET),
      .REQ_A(REQ_A), .DATA_A(DATA_A), .ACK_A(ack_a4),
      .REQ_B(REQ_B), .DATA_B(DATA_B), .ACK_B(ack_b4),
      .SRAM_ADDR(addr4), .SRAM_DATA(data4), .SRAM_CE_N(ce4),
      .SRAM_WE_N(we4), .BUSY(busy4), .FULL(full4)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      m_ack_a  = unit ? ack_a4 : ack_a2;
      m_ack_b  = unit ? ack_b4 : ack_b2;
      m_we_n   = unit ? we4 : we2;
      m_busy   = unit ? busy4 : busy2;
      m_full_o = unit ? full4 : full2;
      m_addr_o = unit ? addr4 : addr2;
      m_data_o = unit ? data4 : data2;
      m_ce_n   = unit ? ce4 : ce2;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_addr   = 18'd0;
      m_chip   = 1'b0;
      m_full   = 1'b0;
      m_last_b = 1'b1;
   endtask

   task automatic model_advance();
      if (m_addr == 18'h3FFFF) begin
         m_addr = 18'd0;
         if (!m_chip) m_chip = 1'b1;
         else begin
`ifdef SRAM_WRAP_EN
            m_chip = 1'b0;
`else
            m_full = 1'b1;
`endif
         end
      end else begin
         m_addr = m_addr + 18'd1;
      end
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      model_reset();
   endtask

   // One word slot: 3+W cycles starting with the IDLE cycle.
   task automatic run_word(input int drop_cyc, output logic act,
                           output logic gb);
      int w, n, we_lo, ce_lo, bsy, na, nb, ca, cb;
      logic [15:0] ed;
      logic [1:0]  ece;
      w = unit ? 4 : 2;
      n = 3 + w;
      act = (REQ_A || REQ_B) && !m_full;
      if (REQ_A && REQ_B) gb = !m_last_b;
      else gb = REQ_B;
      ed  = gb ? DATA_B : DATA_A;
      ece = m_chip ? 2'b01 : 2'b10;
      we_lo = 0; ce_lo = 0; bsy = 0;
      na = 0; nb = 0; ca = 0; cb = 0;
      for (int c = 1; c <= n; c++) begin
         @(negedge CLK);
         if (c == 1) begin
            check("idle_addr", 32'(m_addr_o), 32'(m_addr));
            check("idle_ce", 32'(m_ce_n), 32'(2'b11));
            check("idle_busy", 32'(m_busy), 32'(1'b0));
            check("full", 32'(m_full_o), 32'(m_full));
         end
         if (!m_we_n) we_lo++;
         if (m_ce_n != 2'b11) ce_lo++;
         if (m_busy) bsy++;
         if (m_ack_a) begin na++; ca = c; end
         if (m_ack_b) begin nb++; cb = c; end
         if (c == 2 && act) begin
            check("wr_data", 32'(m_data_o), 32'(ed));
            check("wr_addr", 32'(m_addr_o), 32'(m_addr));
            check("wr_ce", 32'(m_ce_n), 32'(ece));
         end
         if (c == drop_cyc) begin
            if (gb) REQ_B = 1'b0;
            else REQ_A = 1'b0;
         end
      end
      check("we_len", 32'(we_lo), act ? 32'(w) : 32'd0);
      check("ce_len", 32'(ce_lo), act ? 32'(w + 2) : 32'd0);
      check("busy_len", 32'(bsy), act ? 32'(w + 2) : 32'd0);
      check("ack_a_cnt", 32'(na), (act && !gb) ? 32'd1 : 32'd0);
      check("ack_b_cnt", 32'(nb), (act && gb) ? 32'd1 : 32'd0);
      check("ack_a_cyc", 32'(ca), (act && !gb) ? 32'(n) : 32'd0);
      check("ack_b_cyc", 32'(cb), (act && gb) ? 32'(n) : 32'd0);
      if (act) begin
         m_last_b = gb;
         model_advance();
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic random_words(input int count);
      logic act, gb;
      int drop;
      for (int i = 0; i < count; i++) begin
         if (!REQ_A && $urandom_range(0, 2) != 0) begin
            REQ_A = 1'b1;
            DATA_A = 16'($urandom);
         end
         if (!REQ_B && $urandom_range(0, 2) != 0) begin
            REQ_B = 1'b1;
            DATA_B = 16'($urandom);
         end
         drop = ($urandom_range(0, 7) == 0) ? 2 : 0;
         run_word(drop, act, gb);
         if (act) begin
            if (gb) begin
               REQ_B = 1'($urandom_range(0, 1));
               DATA_B = 16'($urandom);
            end else begin
               REQ_A = 1'($urandom_range(0, 1));
               DATA_A = 16'($urandom);
            end
         end
      end
      REQ_A = 1'b0;
      REQ_B = 1'b0;
      run_word(0, act, gb);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic act, gb;
      int acks;
      unit = 1'b0;
      RESET = 1'b0;
      REQ_A = 1'b0; REQ_B = 1'b0;
      DATA_A = 16'd0; DATA_B = 16'd0;
      model_reset();
      @(posedge CLK);
      #1;
      do_reset();

      @(negedge CLK);
      check("rst_addr", 32'(m_addr_o), 32'd0);
      check("rst_data", 32'(m_data_o), 32'd0);
      check("rst_ce", 32'(m_ce_n), 32'(2'b11));
      check("rst_we", 32'(m_we_n), 32'd1);
      check("rst_ack", 32'({m_ack_a, m_ack_b}), 32'd0);
      check("rst_busy", 32'(m_busy), 32'd0);
      check("rst_full", 32'(m_full_o), 32'd0);
      @(posedge CLK);
      #1;

      REQ_A = 1'b1;
      DATA_A = 16'hBEEF;
      run_word(0, act, gb);
      check("single_gnt", 32'(gb), 32'd0);
      REQ_A = 1'b0;
      run_word(0, act, gb);
      check("single_data", 32'(m_data_o), 32'hBEEF);

      do_reset();
      REQ_A = 1'b1; REQ_B = 1'b1;
      DATA_A = 16'($urandom); DATA_B = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
         run_word(0, act, gb);
         check("arb_grant", 32'(gb), 32'(i % 2));
         if (gb) DATA_B = 16'($urandom);
         else DATA_A = 16'($urandom);
      end
      REQ_A = 1'b0; REQ_B = 1'b0;
      run_word(0, act, gb);
      check("arb_addr", 32'(m_addr_o), 32'd4);

      REQ_B = 1'b1;
      DATA_B = 16'($urandom);
      run_word(2, act, gb);
      run_word(0, act, gb);

      REQ_A = 1'b1;
      DATA_A = 16'($urandom);
      repeat (3) @(negedge CLK);
      check("mid_we", 32'(m_we_n), 32'd0);
      RESET = 1'b1;
      @(negedge CLK);
      check("mid_rst_we", 32'(m_we_n), 32'd1);
      check("mid_rst_ce", 32'(m_ce_n), 32'(2'b11));
      check("mid_rst_addr", 32'(m_addr_o), 32'd0);
      check("mid_rst_ack", 32'({m_ack_a, m_ack_b}), 32'd0);
      RESET = 1'b0;
      REQ_A = 1'b0;
      model_reset();
      acks = 0;
      repeat (8) begin
         @(negedge CLK);
         if (m_ack_a || m_ack_b) acks++;
      end
      check("mid_rst_noack", 32'(acks), 32'd0);
      @(posedge CLK);
      #1;

      force u_dut2.r_addr = 18'h3FFFF;
      force u_dut2.r_chip = 1'b0;
      @(posedge CLK);
      #1;
      release u_dut2.r_addr;
      release u_dut2.r_chip;
      m_addr = 18'h3FFFF;
      m_chip = 1'b0;
      REQ_A = 1'b1;
      DATA_A = 16'($urandom);
      run_word(0, act, gb);
      DATA_A = 16'($urandom);
      run_word(0, act, gb);
      check("bnd_chip", 32'(m_chip), 32'd1);
      REQ_A = 1'b0;
      run_word(0, act, gb);

      force u_dut2.r_addr = 18'h3FFFF;
      force u_dut2.r_chip = 1'b1;
      @(posedge CLK);
      #1;
      release u_dut2.r_addr;
      release u_dut2.r_chip;
      m_addr = 18'h3FFFF;
      m_chip = 1'b1;
      REQ_B = 1'b1;
      DATA_B = 16'($urandom);
      run_word(0, act, gb);
      DATA_B = 16'($urandom);
      run_word(0, act, gb);
      run_word(0, act, gb);
      REQ_B = 1'b0;
      run_word(0, act, gb);

      do_reset();
      random_words(40);

      REQ_A = 1'b0; REQ_B = 1'b0;
      unit = 1'b1;
      do_reset();
      REQ_A = 1'b1;
      DATA_A = 16'($urandom);
      run_word(0, act, gb);
      random_words(16);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
